ax301_segment_scanner: RTL and testbench

//  Minibus master that multiplexes the AX301 6-digit LED display without CPU work.

---
 rtl/ax301_segment_scanner.sv | 246 ++++++++++++++++++++++++
 tb/tb_ax301_segment_scanner.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ax301_segment_scanner.sv
// ax301_segment_scanner
//
// Second minibus initiator that refreshes the AX301 six-digit LED display on its own,
// without any CPU work. One digit is hex-decoded per refresh tick. Each digit is sent to the
// display register as a single write of {sel, segment}. When scanning is disabled, one
// all-off word is written so that no digit stays lit.
//
// Parameters
//   CLK_FREQ_HZ     input clock frequency
//   DIGIT_RATE_HZ   digit refresh rate; TICK_DIV = CLK_FREQ_HZ / DIGIT_RATE_HZ (must be >= 2)
//   ADDR_WIDTH      minibus address width
//   DATA_WIDTH      minibus write-data width (>= 14)
//   SEG_ADDR        minibus address of the display register
//   DIGITS          number of digits scanned (1..6)
//   ACTIVE_LOW      1: sel and segment lines are driven active-low (AX301 board)
//   TIMEOUT_CYCLES  maximum number of cycles wen is held while waiting for ready
//
// Ports
//   clk         clock
//   rst         asynchronous active-high reset
//   en          scanning enable
//   value       digit i shows value[4i+3:4i]
//   dp_mask     bit i lights the decimal point of digit i
//   blank_mask  bit i forces all segments of digit i off (DP included)
//   addr        minibus address (SEG_ADDR while wen is high, otherwise 0)
//   wdata       minibus write data: [13:8] sel, [7:0] segments, other bits 0
//   wen         minibus write strobe
//   ren         minibus read strobe (always 0; this master only writes)
//   ready       minibus completion from the slave
//   busy        1 while scanning or while the blanking write is pending
//   err         sticky: some write timed out; cleared only by rst
module ax301_segment_scanner #(
  parameter int unsigned           CLK_FREQ_HZ    = 50_000_000,
  parameter int unsigned           DIGIT_RATE_HZ  = 1_000,
  parameter int unsigned           ADDR_WIDTH     = 16,
  parameter int unsigned           DATA_WIDTH     = 16,
  parameter logic [ADDR_WIDTH-1:0] SEG_ADDR       = '0,
  parameter int unsigned           DIGITS         = 6,
  parameter bit                    ACTIVE_LOW     = 1'b1,
  parameter int unsigned           TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [23:0]           value,
  input  logic [5:0]            dp_mask,
  input  logic [5:0]            blank_mask,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  wen,
  output logic                  ren,
  input  logic                  ready,
  output logic                  busy,
  output logic                  err
);

  localparam int unsigned TICK_DIV = CLK_FREQ_HZ / DIGIT_RATE_HZ;
  localparam int unsigned CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TO_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]       DIGIT_LAST = 3'(DIGITS - 1);

  // All-off word: sel=0 and seg=0 in active-high form, inverted for active-low boards.
  localparam logic [DATA_WIDTH-1:0] BLANK_WORD =
      ACTIVE_LOW ? DATA_WIDTH'(16'h3FFF) : '0;

  typedef enum logic [2:0] {
    StIdle,
    StLatch,
    StWrite,
    StWait,
    StBlank
  } state_e;

  // Hex digit to active-high gfedcba segment pattern.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2:0]            digit_q, digit_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [23:0]           snap_value_q;
  logic [5:0]            snap_dp_q;
  logic [5:0]            snap_blank_q;
  logic                  snap_load;

  logic                  tick;
  logic [23:0]           src_value;
  logic [5:0]            src_dp;
  logic [5:0]            src_blank;
  logic [3:0]            nibble;
  logic [7:0]            seg_on;
  logic [5:0]            sel_on;
  logic [DATA_WIDTH-1:0] digit_word;

  // Refresh tick counter; held at zero while idle so every scan starts on a fresh slot.
  assign tick = (cnt_q == TICK_LAST);

  always_comb begin
    cnt_d = '0;
    if (state_q != StIdle) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  // Digit 0 reads the live inputs (the snapshot is taken in that same cycle); later digits read
  // the snapshot, so a frame never mixes old and new values.
  always_comb begin
    src_value = value;
    src_dp    = dp_mask;
    src_blank = blank_mask;
    if (digit_q != 3'd0) begin
      src_value = snap_value_q;
      src_dp    = snap_dp_q;
      src_blank = snap_blank_q;
    end
    nibble = src_value[{digit_q, 2'b00} +: 4];
    seg_on = {src_dp[digit_q], hex_to_seg(nibble)};
    if (src_blank[digit_q]) begin
      seg_on = 8'h00;
    end
    sel_on            = 6'b000001 << digit_q;
    digit_word        = '0;
    digit_word[13:8]  = ACTIVE_LOW ? ~sel_on : sel_on;
    digit_word[7:0]   = ACTIVE_LOW ? ~seg_on : seg_on;
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    digit_d   = digit_q;
    to_cnt_d  = to_cnt_q;
    err_d     = err_q;
    wdata_d   = wdata_q;
    snap_load = 1'b0;

    case (state_q)
      StIdle: begin
        digit_d = 3'd0;
        if (en) begin
          state_d = StLatch;
        end
      end

      StLatch: begin
        snap_load = (digit_q == 3'd0);
        wdata_d   = digit_word;
        to_cnt_d  = '0;
        state_d   = StWrite;
      end

      StWrite, StBlank: begin
        // A timed-out write is abandoned like a completed one; the scan keeps going.
        if (ready || (to_cnt_q == TO_LAST)) begin
          if (!ready) begin
            err_d = 1'b1;
          end
          if (state_q == StWrite) begin
            state_d = StWait;
          end else begin
            state_d = StIdle;
            digit_d = 3'd0;
          end
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      StWait: begin
        // Disable wins over the tick: blank right away rather than at the slot boundary.
        if (!en) begin
          wdata_d  = BLANK_WORD;
          to_cnt_d = '0;
          state_d  = StBlank;
        end else if (tick) begin
          digit_d = (digit_q == DIGIT_LAST) ? 3'd0 : digit_q + 3'd1;
          state_d = StLatch;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      digit_q      <= 3'd0;
      to_cnt_q     <= '0;
      err_q        <= 1'b0;
      wdata_q      <= '0;
      snap_value_q <= '0;
      snap_dp_q    <= '0;
      snap_blank_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      digit_q  <= digit_d;
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
      wdata_q  <= wdata_d;
      if (snap_load) begin
        snap_value_q <= value;
        snap_dp_q    <= dp_mask;
        snap_blank_q <= blank_mask;
      end
    end
  end

  // Strobes decode straight from state so an asynchronous reset drops them immediately.
  assign wen   = (state_q == StWrite) || (state_q == StBlank);
  assign addr  = wen ? SEG_ADDR : '0;
  assign ren   = 1'b0;
  assign wdata = wdata_q;
  assign busy  = (state_q != StIdle);
  assign err   = err_q;

endmodule

// File: tb/tb_ax301_segment_scanner.sv
`timescale 1ns/1ps
module tb_ax301_segment_scanner;

  localparam int          TICK    = 10;    // 1000 Hz / 100 Hz
  localparam int          NDIG    = 6;
  localparam int          TMO     = 255;
  localparam int          NFRAMES = 6;
  localparam logic [15:0] SEG_A   = 16'h0040;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [23:0] value = '0;
  logic [5:0]  dp_mask = '0;
  logic [5:0]  blank_mask = '0;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        wen;
  logic        ren;
  logic        ready = 1'b0;
  logic        busy;
  logic        err;

  ax301_segment_scanner #(
    .CLK_FREQ_HZ   (1000),
    .DIGIT_RATE_HZ (100),
    .ADDR_WIDTH    (16),
    .DATA_WIDTH    (16),
    .SEG_ADDR      (SEG_A),
    .DIGITS        (NDIG),
    .ACTIVE_LOW    (1'b1),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .value     (value),
    .dp_mask   (dp_mask),
    .blank_mask(blank_mask),
    .addr      (addr),
    .wdata     (wdata),
    .wen       (wen),
    .ren       (ren),
    .ready     (ready),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int hex_tab [16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                       'h7F, 'h6F, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};

  // Active-low word on the bus for digit d of a frame showing v with masks dp/bl.
  function automatic logic [15:0] ref_word(input logic [23:0] v, input logic [5:0] dp,
                                           input logic [5:0] bl, input int d);
    int nib;
    int seg;
    int sel;
    nib = int'(v >> (4 * d)) & 15;
    seg = bl[d] ? 0 : (hex_tab[nib] | (dp[d] ? 128 : 0));
    sel = 1 << d;
    return 16'((32'h3FFF ^ ((sel << 8) | seg)) & 32'hFFFF);
  endfunction

  typedef struct {
    logic [15:0] word;
    int          gap;   // cycles since the previous write started; 0 = not checked
  } exp_t;

  exp_t exp_q[$];
  int   len_q[$];

  task automatic push_frame(input logic [23:0] v, input logic [5:0] dp, input logic [5:0] bl,
                            input int first_gap, input int second_gap);
    exp_t e;
    for (int d = 0; d < NDIG; d++) begin
      e.word = ref_word(v, dp, bl, d);
      e.gap  = (d == 0) ? first_gap : ((d == 1) ? second_gap : TICK);
      exp_q.push_back(e);
    end
  endtask

  // ---------------- slave responder ----------------
  bit rand_ready = 1'b0;
  int fixed_d = 0;
  int stall_next = 0;
  int wcnt = 0;
  int cur_d = 0;

  always @(negedge clk) begin
    if (rst) begin
      ready = 1'b0;
      wcnt  = 0;
    end else if (wen) begin
      if (wcnt == 0) begin
        if (stall_next > 0) begin
          cur_d = 1_000_000;
          stall_next--;
          len_q.push_back(TMO);
        end else begin
          cur_d = rand_ready ? int'($urandom_range(0, 6)) : fixed_d;
          len_q.push_back(cur_d + 1);
        end
      end
      ready = (wcnt == cur_d);
      wcnt++;
    end else begin
      ready = 1'b0;
      wcnt  = 0;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int          cyc = 0;
  bit          in_write = 1'b0;
  int          wlen;
  int          start_cyc;
  int          last_start = 0;
  logic [15:0] cap_w;
  logic [15:0] cap_a;
  bit          stable;
  bit          ren_seen;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    exp_t e;
    #1;
    if (rst) begin
      in_write = 1'b0;
    end else if (wen) begin
      if (!in_write) begin
        in_write  = 1'b1;
        wlen      = 0;
        cap_w     = wdata;
        cap_a     = addr;
        stable    = 1'b1;
        ren_seen  = 1'b0;
        start_cyc = cyc;
      end else if (wdata !== cap_w || addr !== cap_a) begin
        stable = 1'b0;
      end
      if (ren !== 1'b0) ren_seen = 1'b1;
      wlen++;
    end else if (in_write) begin
      in_write = 1'b0;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write: got %0h, required no write (t=%0t)", cap_w, $time);
      end else begin
        e = exp_q.pop_front();
        check("wdata", cap_w, e.word);
        if (e.gap > 0) check("write_spacing", start_cyc - last_start, e.gap);
      end
      check("addr", cap_a, SEG_A);
      check("wdata_addr_stable", stable, 1);
      check("ren_low", ren_seen, 0);
      if (len_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL wen_len: got %0d, required a recorded length", wlen);
      end else begin
        check("wen_len", wlen, len_q.pop_front());
      end
      last_start = start_cyc;
    end
  end

  task automatic wait_drain(input int limit, input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || wen) && k < limit) begin
      @(negedge clk);
      k++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int          pos;
    int          off;
    int          k;
    logic [23:0] nv;
    logic [5:0]  ndp;
    logic [5:0]  nbl;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_wen", wen, 0);
    check("rst_ren", ren, 0);
    check("rst_addr", addr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Continuous scanning, one new frame value per frame, changed mid-frame.
    @(negedge clk);
    value = 24'h012345;
    dp_mask = '0;
    blank_mask = '0;
    fixed_d = 0;
    en = 1'b1;
    push_frame(value, dp_mask, blank_mask, 0, TICK);
    pos = -1;
    for (int f = 0; f < NFRAMES; f++) begin
      off = (f == 0) ? 25 : int'($urandom_range(5, 55));
      repeat (60 * f + off - pos) @(negedge clk);
      pos = 60 * f + off;
      if (f == 0) begin
        check("busy_scanning", busy, 1);
        check("err_clean", err, 0);
        fixed_d = 3;
      end
      if (f == 1) rand_ready = 1'b1;
      if (f < NFRAMES - 1) begin
        case (f)
          0: begin nv = 24'hFFFFFF; ndp = 6'd0; nbl = 6'd0; end
          1: begin nv = 24'h012345; ndp = 6'b000001; nbl = 6'b000010; end
          default: begin
            nv  = 24'($urandom);
            ndp = 6'($urandom);
            nbl = 6'($urandom & $urandom);
          end
        endcase
        value = nv;
        dp_mask = ndp;
        blank_mask = nbl;
        push_frame(nv, ndp, nbl, TICK, TICK);
      end
    end
    // Drop en while the last digit of the last frame sits in its wait slot.
    repeat (60 * NFRAMES - 2 - pos) @(negedge clk);
    en = 1'b0;
    exp_q.push_back('{16'h3FFF, 0});
    wait_drain(100, "drain_scan");
    repeat (2) @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_wen", wen, 0);
    check("idle_err", err, 0);

    // First write never answered: timeout, err sticky, scan continues on the next tick.
    @(negedge clk);
    value = 24'($urandom);
    dp_mask = 6'($urandom);
    blank_mask = '0;
    rand_ready = 1'b0;
    fixed_d = 0;
    stall_next = 1;
    en = 1'b1;
    push_frame(value, dp_mask, blank_mask, 0, ((1 + TMO + TICK - 1) / TICK) * TICK);
    push_frame(value, dp_mask, blank_mask, TICK, TICK);
    repeat (101) @(negedge clk);
    check("err_before_timeout", err, 0);
    repeat (200) @(negedge clk);
    check("err_after_timeout", err, 1);
    repeat (68) @(negedge clk);
    en = 1'b0;
    exp_q.push_back('{16'h3FFF, 0});
    wait_drain(100, "drain_timeout");
    repeat (2) @(negedge clk);
    check("err_sticky", err, 1);
    check("timeout_idle_busy", busy, 0);

    // Reset pulsed in the middle of a write.
    @(negedge clk);
    stall_next = 1;
    en = 1'b1;
    k = 0;
    while (!wen && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("wen_started", wen, 1);
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_wen", wen, 0);
    check("midrst_busy", busy, 0);
    check("midrst_err", err, 0);
    check("midrst_wdata", wdata, 0);
    check("midrst_addr", addr, 0);
    @(negedge clk);
    #2;
    exp_q.delete();
    len_q.delete();
    stall_next = 0;
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_wen", wen, 0);
    check("post_rst_busy", busy, 0);
    check("leftover_expected", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
